// File: rtl/eth_gen_pkg.sv
// eth_gen_pkg -- shared constants, FSM state type and tkeep helper for the
// 10GbE TX test-frame generator.
//   ETHERTYPE      : EtherType written to frame bytes 12-13
//   MIN_LEN        : smallest frame (bytes, FCS excluded) that is emitted
//   gen_state_e    : generator FSM states
//   tkeep_from_rem : last-beat tkeep from ((len-1) % 8)
package eth_gen_pkg;

  localparam logic [15:0] ETHERTYPE = 16'h88B5;
  localparam int          MIN_LEN   = 60;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } gen_state_e;

  // rem_m1 = (len-1) % 8, so the last beat holds rem_m1+1 bytes, low lanes first.
  function automatic logic [7:0] tkeep_from_rem(input logic [2:0] rem_m1);
    return 8'hFF >> (3'd7 - rem_m1);
  endfunction

endpackage

// File: rtl/ten_geth_tx_frame_gen_if.sv
// ten_geth_tx_frame_gen_if -- AXI4-Stream TX beat bus (64-bit data, 8-bit keep)
// between the frame generator (master) and the MAC TX FIFO (slave).
//   tdata/tkeep/tvalid/tlast : master -> slave
//   tready                   : slave -> master
interface ten_geth_tx_frame_gen_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_gen_beat_fmt.sv
// eth_gen_beat_fmt -- combinational beat formatter. Builds the 8 bytes of one
// 64-bit beat from the beat index and the latched header fields.
//   beat_idx : beat number within the frame (byte k = beat_idx*8 + lane)
//   dst_mac  : destination MAC, sent MSB first in bytes 0-5
//   src_mac  : source MAC, sent MSB first in bytes 6-11
//   seq_num  : per-frame sequence number, bytes 14-17 (only with ETH_GEN_SEQNUM_EN)
//   tdata    : byte n in tdata[8n+7:8n]
// Macro ETH_GEN_SEQNUM_EN enables the sequence-number field; otherwise
// bytes 14-17 carry the k[7:0] payload pattern like every other payload byte.
module eth_gen_beat_fmt
  import eth_gen_pkg::*;
(
  input  logic [10:0] beat_idx,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
`ifdef ETH_GEN_SEQNUM_EN
  input  logic [31:0] seq_num,
`endif
  output logic [63:0] tdata
);

`ifdef ETH_GEN_SEQNUM_EN
  localparam int HDR_BYTES = 18;
`else
  localparam int HDR_BYTES = 14;
`endif

  // Header bytes in wire order; the array is padded to a power of two so a
  // 5-bit byte number can index it directly.
  logic [7:0] hdr_b [32];

  always_comb begin
    for (int i = 0; i < 32; i++) hdr_b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      hdr_b[i]     = dst_mac[47-8*i -: 8];
      hdr_b[6 + i] = src_mac[47-8*i -: 8];
    end
    hdr_b[12] = ETHERTYPE[15:8];
    hdr_b[13] = ETHERTYPE[7:0];
`ifdef ETH_GEN_SEQNUM_EN
    for (int i = 0; i < 4; i++) hdr_b[14 + i] = seq_num[31-8*i -: 8];
`endif
  end

  for (genvar n = 0; n < 8; n++) begin : g_lane
    logic [13:0] k;
    assign k = {beat_idx, 3'(n)};
    assign tdata[8*n +: 8] = (k < 14'(HDR_BYTES)) ? hdr_b[k[4:0]] : k[7:0];
  end

endmodule

// File: rtl/ten_geth_tx_frame_gen.sv
// ten_geth_tx_frame_gen -- 10GbE TX test-frame generator. On a start pulse it
// latches the frame parameters and emits frame_cnt frames (0 = until stop)
// on a 64-bit AXI-Stream bus, separated by IFG_CYCLES idle cycles.
//   user_clk, tx_axis_aresetn : clock, async active-low reset
//   start, stop               : burst start pulse / stop-at-frame-boundary level
//   frame_len, frame_cnt      : frame bytes (no FCS, clamped 60..MAX_LEN), frames per burst
//   dst_mac, src_mac          : header addresses
//   tx_axis                   : AXI-Stream master (tdata/tkeep/tvalid/tlast, tready)
//   busy, done, frames_sent   : burst active, burst-finished pulse, frame counter
// Macro ETH_GEN_SEQNUM_EN adds a 32-bit per-frame sequence number in bytes 14-17.
// IFG_CYCLES values below 1 behave as 1 (the gap state lasts at least a cycle).
module ten_geth_tx_frame_gen
  import eth_gen_pkg::*;
#(
  parameter int IFG_CYCLES = 2,
  parameter int MAX_LEN    = 9600
) (
  input  logic                           user_clk,
  input  logic                           tx_axis_aresetn,
  input  logic                           start,
  input  logic                           stop,
  input  logic [13:0]                    frame_len,
  input  logic [15:0]                    frame_cnt,
  input  logic [47:0]                    dst_mac,
  input  logic [47:0]                    src_mac,
  ten_geth_tx_frame_gen_if.master        tx_axis,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    frames_sent
);

  localparam int IFG_LAST = (IFG_CYCLES > 1) ? IFG_CYCLES - 1 : 0;
  localparam int GAP_W    = (IFG_LAST > 0) ? $clog2(IFG_LAST + 1) : 1;

  function automatic logic [13:0] clamp_len(input logic [13:0] l);
    if (l < 14'(MIN_LEN)) return 14'(MIN_LEN);
    if (l > 14'(MAX_LEN)) return 14'(MAX_LEN);
    return l;
  endfunction

  gen_state_e       state_q, state_d;
  logic [10:0]      beat_q, beat_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [13:0]      len_q, len_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      sent_q, sent_d;
  logic             stop_seen_q, stop_seen_d;
  logic [47:0]      dst_q, dst_d;
  logic [47:0]      src_q, src_d;
  logic [31:0]      frames_q, frames_d;
`ifdef ETH_GEN_SEQNUM_EN
  logic [31:0]      seq_q, seq_d;
`endif

  logic [13:0] len_m1;
  logic        is_last;
  logic        send;
  logic        burst_end;
  logic [63:0] fmt_data;

  assign send    = (state_q == ST_SEND);
  assign len_m1  = len_q - 14'd1;
  assign is_last = (beat_q == len_m1[13:3]);
  // A burst ends after frame_cnt frames, or at the first boundary after stop.
  assign burst_end = stop_seen_q || stop || ((cnt_q != 16'd0) && (sent_q == cnt_q));

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sent_d      = sent_q;
    stop_seen_d = stop_seen_q;
    dst_d       = dst_q;
    src_d       = src_q;
    frames_d    = frames_q;
`ifdef ETH_GEN_SEQNUM_EN
    seq_d       = seq_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SEND;
          beat_d      = '0;
          len_d       = clamp_len(frame_len);
          cnt_d       = frame_cnt;
          sent_d      = '0;
          stop_seen_d = 1'b0;
          dst_d       = dst_mac;
          src_d       = src_mac;
        end
      end
      ST_SEND: begin
        if (stop) stop_seen_d = 1'b1;
        if (tx_axis.tready) begin
          if (is_last) begin
            state_d  = ST_GAP;
            beat_d   = '0;
            gap_d    = '0;
            sent_d   = sent_q + 16'd1;
            frames_d = frames_q + 32'd1;
`ifdef ETH_GEN_SEQNUM_EN
            seq_d    = seq_q + 32'd1;
`endif
          end else begin
            beat_d = beat_q + 11'd1;
          end
        end
      end
      ST_GAP: begin
        if (stop) stop_seen_d = 1'b1;
        if (gap_q == GAP_W'(IFG_LAST)) state_d = burst_end ? ST_IDLE : ST_SEND;
        else                            gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      gap_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      sent_q      <= '0;
      stop_seen_q <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      frames_q    <= '0;
`ifdef ETH_GEN_SEQNUM_EN
      seq_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sent_q      <= sent_d;
      stop_seen_q <= stop_seen_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      frames_q    <= frames_d;
`ifdef ETH_GEN_SEQNUM_EN
      seq_q       <= seq_d;
`endif
    end
  end

  eth_gen_beat_fmt u_fmt (
    .beat_idx (beat_q),
    .dst_mac  (dst_q),
    .src_mac  (src_q),
`ifdef ETH_GEN_SEQNUM_EN
    .seq_num  (seq_q),
`endif
    .tdata    (fmt_data)
  );

  // Outputs decode from registered state only, so they hold still through
  // stalls and drop to zero the moment reset is asserted.
  assign tx_axis.tvalid = send;
  assign tx_axis.tlast  = send && is_last;
  assign tx_axis.tkeep  = !send ? 8'h00 : (is_last ? tkeep_from_rem(len_m1[2:0]) : 8'hFF);
  assign tx_axis.tdata  = send ? fmt_data : 64'd0;

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_GAP) && (state_d == ST_IDLE);
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_ten_geth_tx_frame_gen.sv
// Self-checking bench for ten_geth_tx_frame_gen: random MACs, lengths and
// tready patterns compared against a byte-stream model of the frame format.
module tb_ten_geth_tx_frame_gen;

  logic        user_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [13:0] frame_len = '0;
  logic [15:0] frame_cnt = '0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic        busy, done;
  logic [31:0] frames_sent;

  ten_geth_tx_frame_gen_if axis_if ();

  ten_geth_tx_frame_gen #(.IFG_CYCLES(2), .MAX_LEN(9600)) dut (
    .user_clk        (user_clk),
    .tx_axis_aresetn (rst_n),
    .start           (start),
    .stop            (stop),
    .frame_len       (frame_len),
    .frame_cnt       (frame_cnt),
    .dst_mac         (dst_mac),
    .src_mac         (src_mac),
    .tx_axis         (axis_if),
    .busy            (busy),
    .done            (done),
    .frames_sent     (frames_sent)
  );

  always #5 user_clk = ~user_clk;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_keeps[$];
  int rx_lead, rx_viol;
  bit rx_timeout;

  // ---------------- reference model ----------------
  function automatic int clamp(input int l);
    if (l < 60) return 60;
    if (l > 9600) return 9600;
    return l;
  endfunction

  function automatic logic [7:0] model_byte(input int k, input logic [47:0] d,
                                            input logic [47:0] s, input int unsigned seq);
    logic [47:0] t;
    logic [31:0] sv;
    t = '0;
    sv = seq;
    if (k < 6)  begin t = d >> (8 * (5 - k));  return t[7:0]; end
    if (k < 12) begin t = s >> (8 * (11 - k)); return t[7:0]; end
    if (k == 12) return 8'h88;
    if (k == 13) return 8'hB5;
`ifdef ETH_GEN_SEQNUM_EN
    if (k < 18) begin sv = sv >> (8 * (17 - k)); return sv[7:0]; end
`endif
    return k[7:0];
  endfunction

  task automatic build_exp(input int len, input logic [47:0] d, input logic [47:0] s,
                           input int unsigned seq);
    exp_q.delete();
    for (int k = 0; k < clamp(len); k++) exp_q.push_back(model_byte(k, d, s, seq));
  endtask

  function automatic int first_diff();
    if (rx_q.size() != exp_q.size())
      return (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // ---------------- stimulus / capture ----------------
  task automatic do_reset();
    @(negedge user_clk);
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    repeat (2) @(negedge user_clk);
    rst_n = 1'b1;
    exp_frames = 0;
  endtask

  task automatic start_burst(input int len, input int cnt, input logic [47:0] d,
                             input logic [47:0] s);
    @(negedge user_clk);
    frame_len = 14'(len);
    frame_cnt = 16'(cnt);
    dst_mac = d;
    src_mac = s;
    start = 1'b1;
  endtask

  // Captures one frame. tready is chosen at each falling edge before the
  // sample, so the sampled value is the one the next rising edge sees.
  task automatic recv_frame(input int rdy_pct, input int stop_beat, input int poke_beat);
    int cyc;
    bit got_last, stalled, seen;
    logic [63:0] pd;
    logic [7:0] pk;
    logic pl;
    cyc = 0; got_last = 0; stalled = 0; seen = 0;
    pd = '0; pk = '0; pl = 1'b0;
    rx_q.delete(); rx_keeps.delete();
    rx_lead = 0; rx_viol = 0; rx_timeout = 0;
    while (!got_last && !rx_timeout) begin
      @(negedge user_clk);
      start = 1'b0;
      axis_if.tready = ($urandom_range(0, 99) < rdy_pct);
      if (stalled && (axis_if.tvalid !== 1'b1 || axis_if.tdata !== pd ||
                      axis_if.tkeep !== pk || axis_if.tlast !== pl)) rx_viol++;
      if (axis_if.tvalid !== 1'b1) begin
        if (!seen) rx_lead++;
      end else seen = 1;
      stalled = (axis_if.tvalid === 1'b1) && (axis_if.tready === 1'b0);
      pd = axis_if.tdata; pk = axis_if.tkeep; pl = axis_if.tlast;
      if (axis_if.tvalid === 1'b1 && axis_if.tready === 1'b1) begin
        rx_keeps.push_back(axis_if.tkeep);
        for (int n = 0; n < 8; n++)
          if (axis_if.tkeep[n]) rx_q.push_back(axis_if.tdata[8*n +: 8]);
        if (stop_beat >= 0 && rx_keeps.size() == stop_beat) stop = 1'b1;
        if (poke_beat >= 0 && rx_keeps.size() == poke_beat) begin
          start = 1'b1;
          frame_len = 14'd200;
          dst_mac = ~dst_mac;
        end
        got_last = (axis_if.tlast === 1'b1);
        if (got_last) exp_frames++;
      end
      cyc++;
      if (cyc > 20000) rx_timeout = 1;
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 200) begin
      @(negedge user_clk);
      c++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy still %b after %0d cycles, want 0", name, busy, c);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge user_clk);
    checks++;
    if (axis_if.tvalid !== 1'b0 || axis_if.tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset valid/last: got %b/%b want 0/0", axis_if.tvalid, axis_if.tlast);
    end
    checks++;
    if (axis_if.tdata !== 64'd0 || axis_if.tkeep !== 8'd0) begin
      errors++;
      $display("FAIL reset data/keep: got %h/%h want 0/0", axis_if.tdata, axis_if.tkeep);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || frames_sent !== 32'd0) begin
      errors++;
      $display("FAIL reset status: busy=%b done=%b frames=%0d want 0 0 0", busy, done, frames_sent);
    end
    rst_n = 1'b1;
    stop = 1'b1;
    begin
      int act;
      act = 0;
      repeat (6) begin
        @(negedge user_clk);
        if (axis_if.tvalid !== 1'b0 || busy !== 1'b0) act++;
      end
      checks++;
      if (act != 0) begin
        errors++;
        $display("FAIL idle_after_reset: got %0d active cycles want 0", act);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_basic();
    logic [47:0] d, s;
    int dn, bad_keep;
    do_reset();
    d = {$urandom, $urandom}; s = {$urandom, $urandom};
    build_exp(64, d, s, 0);
    start_burst(64, 1, d, s);
    recv_frame(100, -1, -1);
    checks++;
    if (rx_timeout || rx_lead != 0) begin
      errors++;
      $display("FAIL basic latency: got lead=%0d timeout=%0d want 0 0", rx_lead, rx_timeout);
    end
    checks++;
    if (rx_keeps.size() != 8) begin
      errors++;
      $display("FAIL basic beats: got %0d want 8", rx_keeps.size());
    end
    bad_keep = 0;
    foreach (rx_keeps[i]) if (rx_keeps[i] !== 8'hFF) bad_keep++;
    checks++;
    if (bad_keep != 0) begin
      errors++;
      $display("FAIL basic tkeep: got %0d beats not FF want 0", bad_keep);
    end
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("FAIL basic bytes: first diff at %0d got %0d bytes want %0d",
               first_diff(), rx_q.size(), exp_q.size());
    end
    dn = 0;
    repeat (8) begin
      @(negedge user_clk);
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL basic done: got %0d pulses want 1", dn);
    end
    checks++;
    if (frames_sent !== 32'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic status: frames=%0d busy=%b want 1 0", frames_sent, busy);
    end
  endtask

  task automatic test_keep();
    int lens[3] = '{61, 10, 9999};
    logic [7:0] last_keep[3] = '{8'h1F, 8'h0F, 8'hFF};
    int beats[3] = '{8, 8, 1200};
    logic [47:0] d, s;
    foreach (lens[i]) begin
      d = {$urandom, $urandom}; s = {$urandom, $urandom};
      build_exp(lens[i], d, s, exp_frames);
      start_burst(lens[i], 1, d, s);
      recv_frame(i == 2 ? 100 : 80, -1, i == 0 ? 3 : -1);
      checks++;
      if (rx_timeout || rx_keeps.size() != beats[i]) begin
        errors++;
        $display("FAIL keep len=%0d beats: got %0d want %0d", lens[i], rx_keeps.size(), beats[i]);
      end else begin
        checks++;
        if (rx_keeps[beats[i]-1] !== last_keep[i]) begin
          errors++;
          $display("FAIL keep len=%0d last tkeep: got %h want %h", lens[i],
                   rx_keeps[beats[i]-1], last_keep[i]);
        end
      end
      checks++;
      if (first_diff() != -1) begin
        errors++;
        $display("FAIL keep len=%0d bytes: first diff at %0d got %0d bytes want %0d",
                 lens[i], first_diff(), rx_q.size(), exp_q.size());
      end
      wait_idle("keep");
    end
  endtask

  task automatic test_random_stall();
    logic [47:0] d, s;
    int len;
    for (int f = 0; f < 6; f++) begin
      d = {$urandom, $urandom}; s = {$urandom, $urandom};
      len = $urandom_range(40, 300);
      build_exp(len, d, s, exp_frames);
      start_burst(len, 1, d, s);
      recv_frame(50, -1, -1);
      checks++;
      if (rx_timeout || rx_viol != 0) begin
        errors++;
        $display("FAIL stall f%0d stability: got %0d violations timeout=%0d want 0",
                 f, rx_viol, rx_timeout);
      end
      checks++;
      if (first_diff() != -1) begin
        errors++;
        $display("FAIL stall f%0d len=%0d bytes: first diff at %0d got %0d want %0d",
                 f, len, first_diff(), rx_q.size(), exp_q.size());
      end
      wait_idle("stall");
    end
    checks++;
    if (frames_sent !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL stall frames_sent: got %0d want %0d", frames_sent, exp_frames);
    end
  endtask

  task automatic test_stop();
    logic [47:0] d, s;
    int len, dn, vld;
    do_reset();
    d = {$urandom, $urandom}; s = {$urandom, $urandom};
    len = $urandom_range(60, 120);
    start_burst(len, 0, d, s);
    for (int f = 0; f < 3; f++) begin
      build_exp(len, d, s, f);
      recv_frame(70, f == 2 ? 2 : -1, -1);
      checks++;
      if (rx_timeout || first_diff() != -1) begin
        errors++;
        $display("FAIL stop frame%0d bytes: first diff at %0d timeout=%0d", f + 1,
                 first_diff(), rx_timeout);
      end
    end
    dn = 0; vld = 0;
    repeat (30) begin
      @(negedge user_clk);
      if (done === 1'b1) dn++;
      if (axis_if.tvalid === 1'b1) vld++;
    end
    checks++;
    if (vld != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop extra: got %0d valid cycles busy=%b want 0 0", vld, busy);
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL stop done: got %0d pulses want 1", dn);
    end
    checks++;
    if (frames_sent !== 32'd3) begin
      errors++;
      $display("FAIL stop frames_sent: got %0d want 3", frames_sent);
    end
    stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [47:0] d, s;
    int nb, act;
    do_reset();
    d = {$urandom, $urandom}; s = {$urandom, $urandom};
    start_burst(128, 1, d, s);
    axis_if.tready = 1'b1;
    nb = 0;
    for (int c = 0; c < 50 && nb < 4; c++) begin
      @(negedge user_clk);
      start = 1'b0;
      if (axis_if.tvalid === 1'b1) nb++;
    end
    @(negedge user_clk);
    checks++;
    if (axis_if.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid beat4 valid: got %b want 1", axis_if.tvalid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (axis_if.tvalid !== 1'b0 || busy !== 1'b0 || axis_if.tdata !== 64'd0 ||
        axis_if.tkeep !== 8'd0 || frames_sent !== 32'd0) begin
      errors++;
      $display("FAIL rstmid async: valid=%b busy=%b data=%h keep=%h frames=%0d want all 0",
               axis_if.tvalid, busy, axis_if.tdata, axis_if.tkeep, frames_sent);
    end
    @(negedge user_clk);
    rst_n = 1'b1;
    exp_frames = 0;
    act = 0;
    repeat (4) begin
      @(negedge user_clk);
      if (axis_if.tvalid !== 1'b0 || busy !== 1'b0) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL rstmid stays idle: got %0d active cycles want 0", act);
    end
    build_exp(128, d, s, 0);
    start_burst(128, 1, d, s);
    recv_frame(100, -1, -1);
    checks++;
    if (rx_timeout || rx_lead != 0 || rx_keeps.size() != 16 || first_diff() != -1) begin
      errors++;
      $display("FAIL rstmid restart: lead=%0d beats=%0d diff=%0d want 0 16 -1",
               rx_lead, rx_keeps.size(), first_diff());
    end
    wait_idle("rstmid");
  endtask

  task automatic test_seq_ifg();
    logic [47:0] d, s;
    int dn;
    do_reset();
    d = {$urandom, $urandom}; s = {$urandom, $urandom};
    start_burst(64, 3, d, s);
    for (int f = 0; f < 3; f++) begin
      build_exp(64, d, s, f);
      recv_frame(60, -1, -1);
      checks++;
      if (rx_timeout || rx_lead != (f == 0 ? 0 : 2)) begin
        errors++;
        $display("FAIL seq frame%0d gap: got %0d idle cycles want %0d", f + 1, rx_lead,
                 f == 0 ? 0 : 2);
      end
      checks++;
      if (first_diff() != -1) begin
        errors++;
        $display("FAIL seq frame%0d bytes: first diff at %0d got %h want %h", f + 1,
                 first_diff(), rx_q.size() > 14 ? rx_q[14] : 8'h00, exp_q[14]);
      end
    end
    dn = 0;
    repeat (10) begin
      @(negedge user_clk);
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn != 1 || frames_sent !== 32'd3) begin
      errors++;
      $display("FAIL seq end: done pulses=%0d frames=%0d want 1 3", dn, frames_sent);
    end
  endtask

  initial begin
    axis_if.tready = 1'b0;
    test_reset();
    test_basic();
    test_keep();
    test_random_stall();
    test_stop();
    test_reset_mid();
    test_seq_ifg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ten_geth_tx_frame_gen.md
TEN_GETH_TX_FRAME_GEN -- requirements
Module: ten_geth_tx_frame_gen

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 2: idle cycles (tvalid low) between frames.
REQ-002 SHALL have parameter MAX_LEN, default 9600: maximum frame_len in bytes.
REQ-003 user_clk  in  1  sole clock; the block has one clock, and reset is asynchronous and active-low.
REQ-004 tx_axis_aresetn  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle pulse that begins a burst.
REQ-006 stop  in  1  level; ends the burst at the next frame boundary.
REQ-007 frame_len  in  14  frame bytes excluding FCS; latched at start.
REQ-008 frame_cnt  in  16  frames per burst, 0 = continuous; latched at start.
REQ-009 dst_mac, src_mac  in  48 each  header addresses; latched at start.
REQ-010 tx_axis_tdata  out  64; byte n of a beat is in tdata[8n+7:8n].
REQ-011 tx_axis_tkeep  out  8; tx_axis_tvalid, tx_axis_tlast  out  1 each; tx_axis_tready  in  1 (MAC TX FIFO ready).
REQ-012 busy  out  1; done  out  1 (one-cycle pulse); frames_sent  out  32 (frames sent since reset).

Function
REQ-013 SHALL implement FSM IDLE -> SEND on start; SEND -> GAP on the tlast handshake; GAP -> SEND after IFG_CYCLES cycles; GAP -> IDLE when the burst is complete or stop was seen.
REQ-014 SHALL clamp the latched frame_len to the range 60..MAX_LEN.
REQ-015 SHALL emit ceil(len/8) beats; every beat except the last SHALL have tkeep=8'hFF; the last beat SHALL have tkeep with ((len-1)%8)+1 contiguous low ones and tlast=1.
REQ-016 Frame bytes SHALL be: 0-5 = dst_mac MSB first; 6-11 = src_mac MSB first; 12-13 = 8'h88, 8'hB5; each byte k>=14 = k[7:0].
REQ-017 While tvalid=1 and tready=0, tdata/tkeep/tlast/tvalid SHALL hold stable; the beat index SHALL advance only on tvalid&&tready.
REQ-018 The first beat SHALL have tvalid=1 in the cycle after start is sampled in IDLE (latency 1).
REQ-019 start while busy SHALL be ignored; stop during SEND SHALL let the current frame finish; stop in IDLE SHALL have no effect.
REQ-020 frames_sent SHALL increment on each tlast handshake and wrap at 2^32; done SHALL pulse on the GAP->IDLE transition.
REQ-021 busy SHALL be 1 in SEND and GAP.

Reset
REQ-022 Assertion SHALL force IDLE immediately, even mid-frame: tvalid, tlast, busy and done = 0; tdata and tkeep = 0; frames_sent = 0; latched fields = 0.
REQ-023 After deassertion the block SHALL stay in IDLE until a new start pulse.

Configuration
REQ-024 With ETH_GEN_SEQNUM_EN defined, bytes 14-17 SHALL carry a 32-bit per-frame sequence number, MSB first, that starts at 0 at reset and increments per frame; without the macro those bytes SHALL follow the k[7:0] pattern.

Structure
REQ-025 Package eth_gen_pkg SHALL hold the ETHERTYPE constant (16'h88B5), MIN_LEN (60), the FSM state enum, and the tkeep-from-remainder function.
REQ-026 Sub-module eth_gen_beat_fmt (combinational: beat index, header fields, seq number -> tdata) SHALL be instantiated once.

Verification
REQ-027 len=64, cnt=1, tready=1: 8 beats, all tkeep=FF, tlast on beat 7, done once, frames_sent=1.
REQ-028 len=61: beat 7 has tkeep=8'h1F; len=10 (clamped to 60): beat 7 has tkeep=8'h0F.
REQ-029 tready toggled randomly with 50% duty: outputs are stable during stalls, and the byte stream matches REQ-016 exactly.
REQ-030 cnt=0, stop asserted during frame 3: frame 3 completes with tlast, then IDLE, frames_sent=3, and done pulses once.
REQ-031 Reset asserted at beat 4: tvalid=0 in the same cycle; after release, start produces a full frame from beat 0.
REQ-032 With ETH_GEN_SEQNUM_EN, cnt=3: bytes 14-17 are 00000000, 00000001, 00000002 in frames 1 to 3; IFG is exactly 2 idle cycles.
